// File: rtl/seven_seg_scanner_if.sv
// Display bundle for seven_seg_scanner: BCD digits and per-digit controls in,
// multiplexed common-anode drive out.
//   master: produces digits/masks, observes display drive (clock core / testbench)
//   slave : consumes digits/masks, produces display drive (scanner)
interface seven_seg_scanner_if;
  logic [3:0] digit0;        // rightmost digit
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;        // leftmost digit
  logic [3:0] dp_mask;       // bit k -> decimal point on digit k
  logic [3:0] blink_mask;    // bit k -> digit k blinks
  logic       blank_leading; // suppress leading zeros on digits 3..1
  logic [6:0] seg;           // {g,f,e,d,c,b,a}, active-low
  logic       dp;            // decimal point, active-low
  logic [3:0] an;            // anode select, active-low
  logic       frame_tick;    // one-cycle pulse per full scan frame

  modport master (
    output digit0, digit1, digit2, digit3, dp_mask, blink_mask, blank_leading,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  digit0, digit1, digit2, digit3, dp_mask, blink_mask, blank_leading,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit owns a SCAN_DIV-cycle slot; the first BLANK_GAP cycles of a slot keep all
// anodes off to avoid ghosting. Digit value, decimal point, leading-zero blank and blink
// state are captured once at slot start. All state moves on the falling edge of MCLK.
// Ports:
//   MCLK        - master clock (falling-edge active)
//   resetSignal - asynchronous active-low reset
//   disp        - display bundle (slave side): digits/masks in, seg/dp/an/frame_tick out
module seven_seg_scanner #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_GAP  = 500,
  parameter int unsigned BLINK_HALF = 32
) (
  input  logic                MCLK,
  input  logic                resetSignal,
  seven_seg_scanner_if.slave  disp
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned FW = $clog2(BLINK_HALF) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_HALF - 1);

  // Scan state
  logic [PW-1:0] prescaler;
  logic [1:0]    slot;
  logic [FW-1:0] frameCnt;
  logic          blinkPhase;

  // Values captured at slot start
  logic [3:0]    digitLat;
  logic          dpLat;
  logic          darkLat;

  // Registered display drive
  logic [6:0]    segQ;
  logic          dpQ;
  logic [3:0]    anQ;
  logic          frameTickQ;

  // Next-state helpers
  logic          prescWrap;
  logic          frameEnd;
  logic          frameWrap;
  logic [1:0]    slotNext;
  logic          blinkPhaseNext;
  logic [3:0]    digitSel;
  logic          dpSel;
  logic          blankSel;
  logic          blinkSel;
  logic          inGap;

  // Active-high segment pattern; invalid BCD shows a dash
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Slot sequencing, blink phase and the capture values for the slot about to start
  always_comb begin
    prescWrap      = (prescaler == PRESC_LAST);
    frameEnd       = prescWrap && (slot == 2'd3);
    frameWrap      = frameEnd && (frameCnt == FRAME_LAST);
    slotNext       = prescWrap ? slot + 2'd1 : slot;
    // Capture for slot0 happens on the same edge the phase may toggle, so use the new phase
    blinkPhaseNext = frameWrap ? ~blinkPhase : blinkPhase;
    inGap          = (32'(prescaler) < BLANK_GAP);

    digitSel = disp.digit0;
    blankSel = 1'b0;
    case (slotNext)
      2'd3: begin
        digitSel = disp.digit3;
        blankSel = disp.blank_leading && (disp.digit3 == 4'd0);
      end
      2'd2: begin
        digitSel = disp.digit2;
        blankSel = disp.blank_leading && (disp.digit3 == 4'd0) && (disp.digit2 == 4'd0);
      end
      2'd1: begin
        digitSel = disp.digit1;
        blankSel = disp.blank_leading && (disp.digit3 == 4'd0) && (disp.digit2 == 4'd0)
                   && (disp.digit1 == 4'd0);
      end
      default: begin
        digitSel = disp.digit0;
        blankSel = 1'b0;
      end
    endcase

    dpSel    = disp.dp_mask[slotNext];
    blinkSel = disp.blink_mask[slotNext] && blinkPhaseNext;
  end

  // State and output registers; outputs reflect the state held before this edge
  always_ff @(negedge MCLK or negedge resetSignal) begin
    if (!resetSignal) begin
      prescaler  <= '0;
      slot       <= 2'd0;
      frameCnt   <= '0;
      blinkPhase <= 1'b0;
      digitLat   <= 4'd0;
      dpLat      <= 1'b0;
      darkLat    <= 1'b0;
      segQ       <= 7'h7F;
      dpQ        <= 1'b1;
      anQ        <= 4'hF;
      frameTickQ <= 1'b0;
    end else begin
      prescaler  <= prescWrap ? '0 : prescaler + PW'(1);
      slot       <= slotNext;
      blinkPhase <= blinkPhaseNext;
      frameTickQ <= frameEnd;

      if (frameEnd) begin
        frameCnt <= frameWrap ? '0 : frameCnt + FW'(1);
      end

      if (prescWrap) begin
        digitLat <= digitSel;
        dpLat    <= dpSel;
        darkLat  <= blankSel || blinkSel;
      end

      // A dark digit (blanked or blinked off) keeps anode, segments and dp all off
      if (inGap || darkLat) begin
        anQ  <= 4'hF;
        segQ <= 7'h7F;
        dpQ  <= 1'b1;
      end else begin
        anQ  <= ~(4'b0001 << slot);
        segQ <= ~decode(digitLat);
        dpQ  <= ~dpLat;
      end
    end
  end

  assign disp.seg        = segQ;
  assign disp.dp         = dpQ;
  assign disp.an         = anQ;
  assign disp.frame_tick = frameTickQ;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (SCAN_DIV=8, BLANK_GAP=2, BLINK_HALF=2).
// Expectations are keyed by k = number of falling MCLK edges since reset release;
// the monitor samples on the rising edge and compares every entry due at that k.
module tb_seven_seg_scanner;

  localparam int unsigned SCAN_DIV   = 8;
  localparam int unsigned BLANK_GAP  = 2;
  localparam int unsigned BLINK_HALF = 2;

  logic MCLK = 1'b1;
  logic resetSignal;

  seven_seg_scanner_if disp();

  seven_seg_scanner #(
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_GAP  (BLANK_GAP),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .MCLK        (MCLK),
    .resetSignal (resetSignal),
    .disp        (disp)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    int         k;
    string      name;
    bit         chkAn;
    bit         chkSeg;
    bit         chkDp;
    bit         chkFt;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t sb[$];
  int   k       = 0;
  int   nChecks = 0;
  int   nFails  = 0;

  // Falling-edge counter since release
  always @(negedge MCLK) k <= resetSignal ? k + 1 : 0;

  // Sorted insert so stimulus phases may push out of order
  function automatic void push(int kk, string nm, bit cAn, logic [3:0] an, bit cSeg,
                               logic [6:0] seg, bit cDp, logic dp, bit cFt, logic ft);
    exp_t e;
    int   i;
    e.k = kk; e.name = nm;
    e.chkAn = cAn; e.chkSeg = cSeg; e.chkDp = cDp; e.chkFt = cFt;
    e.an = an; e.seg = seg; e.dp = dp; e.ft = ft;
    i = 0;
    while (i < sb.size() && sb[i].k <= kk) i++;
    sb.insert(i, e);
  endfunction

  function automatic void expAn(int kk, string nm, logic [3:0] an);
    push(kk, nm, 1'b1, an, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic void expDigit(int kk, string nm, logic [3:0] an, logic [6:0] seg, logic dp);
    push(kk, nm, 1'b1, an, 1'b1, seg, 1'b1, dp, 1'b0, 1'b0);
  endfunction

  function automatic void expFt(int kk, string nm, logic ft);
    push(kk, nm, 1'b0, 4'h0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, ft);
  endfunction

  task automatic cmp(string nm, int kk, logic [31:0] act, logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s at k=%0d: got %h, expected %h", nm, kk, act, req);
    end
  endtask

  // Monitor: off-state while in reset, scoreboard entries otherwise
  exp_t e;
  always begin
    @(posedge MCLK or negedge resetSignal);
    if (!resetSignal) begin
      #1;
      cmp("reset_an",  k, 32'(disp.an),         32'hF);
      cmp("reset_seg", k, 32'(disp.seg),        32'h7F);
      cmp("reset_dp",  k, 32'(disp.dp),         32'h1);
      cmp("reset_ft",  k, 32'(disp.frame_tick), 32'h0);
    end else begin
      while (sb.size() > 0 && sb[0].k <= k) begin
        e = sb.pop_front();
        if (e.k != k) begin
          nChecks++;
          nFails++;
          $display("FAIL %s: sample k=%0d missed, now k=%0d", e.name, e.k, k);
        end else begin
          if (e.chkAn)  cmp({e.name, "_an"},  k, 32'(disp.an),         32'(e.an));
          if (e.chkSeg) cmp({e.name, "_seg"}, k, 32'(disp.seg),        32'(e.seg));
          if (e.chkDp)  cmp({e.name, "_dp"},  k, 32'(disp.dp),         32'(e.dp));
          if (e.chkFt)  cmp({e.name, "_ft"},  k, 32'(disp.frame_tick), 32'(e.ft));
        end
      end
    end
  end

  task automatic wait_k(int n);
    int guard;
    guard = 0;
    while (k != n) begin
      @(posedge MCLK);
      guard++;
      if (guard > 2000) begin
        $display("FAIL wait_k: k=%0d never reached %0d", k, n);
        $fatal(1, "stimulus timeout");
      end
    end
  endtask

  initial begin
    resetSignal        = 1'b0;
    disp.digit3        = 4'd4;
    disp.digit2        = 4'd3;
    disp.digit1        = 4'd2;
    disp.digit0        = 4'd1;
    disp.dp_mask       = 4'b0000;
    disp.blink_mask    = 4'b0000;
    disp.blank_leading = 1'b0;
    repeat (3) @(posedge MCLK);

    // Scan order, anti-ghost gap, frame tick; slot0 of frame 0 shows the reset-cleared latch
    for (int sl = 0; sl < 4; sl++) begin
      expAn(8*sl + 1, "t1_gap_p0", 4'hF);
      expAn(8*sl + 2, "t1_gap_p1", 4'hF);
      expAn(8*sl + 3, "t1_lit_p2", 4'(~(4'b0001 << sl)));
      expAn(8*sl + 8, "t1_lit_p7", 4'(~(4'b0001 << sl)));
    end
    expDigit(5,  "t1_slot0", 4'b1110, 7'h40, 1'b1);
    expDigit(13, "t1_slot1", 4'b1101, 7'h24, 1'b1);
    expDigit(21, "t1_slot2", 4'b1011, 7'h30, 1'b1);
    expDigit(29, "t1_slot3", 4'b0111, 7'h19, 1'b1);
    expFt(31, "t1_ft_before", 1'b0);
    expFt(32, "t1_ft_wrap",   1'b1);
    expFt(33, "t1_ft_after",  1'b0);
    expFt(64, "t1_ft_wrap2",  1'b1);
    resetSignal = 1'b1;

    // Decode and decimal point on digit0
    wait_k(12);
    disp.digit0  = 4'd0;
    disp.dp_mask = 4'b0001;
    expDigit(37, "t2_dec0",   4'b1110, 7'h40, 1'b0);
    expDigit(45, "t2_slot1",  4'b1101, 7'h24, 1'b1);
    wait_k(44);
    disp.digit0 = 4'd1;
    expDigit(69, "t2_dec1",   4'b1110, 7'h79, 1'b0);
    wait_k(76);
    disp.digit0 = 4'd8;
    expDigit(101, "t2_dec8",  4'b1110, 7'h00, 1'b0);
    expDigit(109, "t2_slot1b", 4'b1101, 7'h24, 1'b1);
    wait_k(108);
    disp.digit0 = 4'd12;
    expDigit(133, "t2_dec12", 4'b1110, 7'h3F, 1'b0);

    // Leading-zero blanking: 0,0,5,0
    wait_k(140);
    disp.digit3        = 4'd0;
    disp.digit2        = 4'd0;
    disp.digit1        = 4'd5;
    disp.digit0        = 4'd0;
    disp.dp_mask       = 4'b0000;
    disp.blank_leading = 1'b1;
    expDigit(165, "t3_bl_slot0", 4'b1110, 7'h40, 1'b1);
    expDigit(173, "t3_bl_slot1", 4'b1101, 7'h12, 1'b1);
    expAn(181, "t3_bl_slot2", 4'hF);
    expAn(189, "t3_bl_slot3", 4'hF);
    wait_k(190);
    disp.blank_leading = 1'b0;
    expDigit(197, "t3_nb_slot0", 4'b1110, 7'h40, 1'b1);
    expDigit(205, "t3_nb_slot1", 4'b1101, 7'h12, 1'b1);
    expDigit(213, "t3_nb_slot2", 4'b1011, 7'h40, 1'b1);
    expDigit(221, "t3_nb_slot3", 4'b0111, 7'h40, 1'b1);

    // Mid-slot input change is held off until the slot comes round again
    wait_k(204);
    disp.digit1 = 4'd3;
    expDigit(237, "t5_hold_p4", 4'b1101, 7'h30, 1'b1);
    expDigit(240, "t5_hold_p7", 4'b1101, 7'h30, 1'b1);
    expDigit(269, "t5_next",    4'b1101, 7'h78, 1'b1);
    wait_k(236);
    disp.digit1 = 4'd7;

    // Async reset mid slot2
    expDigit(276, "t6_pre_reset", 4'b1011, 7'h40, 1'b1);
    wait_k(277);
    resetSignal = 1'b0;
    repeat (3) @(posedge MCLK);

    // Blink on digits 1,0 after restart; dp on digit0 follows the blink
    disp.digit3     = 4'd9;
    disp.digit2     = 4'd6;
    disp.digit1     = 4'd3;
    disp.digit0     = 4'd4;
    disp.dp_mask    = 4'b0001;
    disp.blink_mask = 4'b0011;
    expAn(1, "t6_restart_gap", 4'hF);
    expAn(3, "t6_restart_slot0", 4'b1110);
    expDigit(5, "t4_f0_slot0", 4'b1110, 7'h40, 1'b1);
    expFt(32, "t6_ft", 1'b1);
    for (int f = 0; f < 6; f++) begin
      bit vis;
      vis = ((f / 2) % 2) == 0;
      if (f != 0) begin
        if (vis) expDigit(32*f + 5, "t4_slot0_lit",  4'b1110, 7'h19, 1'b0);
        else     expDigit(32*f + 5, "t4_slot0_dark", 4'hF,    7'h7F, 1'b1);
      end
      if (vis) expDigit(32*f + 13, "t4_slot1_lit",  4'b1101, 7'h30, 1'b1);
      else     expDigit(32*f + 13, "t4_slot1_dark", 4'hF,    7'h7F, 1'b1);
      expDigit(32*f + 21, "t4_slot2", 4'b1011, 7'h02, 1'b1);
      expDigit(32*f + 29, "t4_slot3", 4'b0111, 7'h10, 1'b1);
    end
    resetSignal = 1'b1;

    wait_k(192);
    repeat (2) @(posedge MCLK);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations never sampled", sb.size());
      $fatal(1, "undrained scoreboard");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
